// File: rtl/rf_pkg.sv
// Shared register-file constants for the writeback arbiter and its sub-blocks.
package rf_pkg;
   localparam int RF_ADDR_W    = 3;
   localparam int RF_DATA_W    = 16;
   localparam int SQUASH_CNT_W = 8;

   localparam logic [RF_ADDR_W-1:0]    RF_ZERO_REG    = 3'd0;
   localparam logic [SQUASH_CNT_W-1:0] SQUASH_CNT_MAX = '1;
endpackage

// File: rtl/regfile_wb_arbiter_rr_grant.sv
// Combinational rotate-priority arbiter: the first requester at or after ptr
// (modulo NUM_REQ) wins. The outputs are a one-hot grant and the winner's index.
module rr_grant #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);
   logic found;
   int   idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDX_W'(idx);
         end
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port among NUM_REQ writeback sources.
// The optional forwarding compare (fwd_addr1..3 / fwd_hit) is enabled by defining RF_WB_FORWARD_EN.
module regfile_wb_arbiter
   import rf_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = RF_ADDR_W,
   parameter int DATA_W  = RF_DATA_W
) (
   input  logic                      CLK,
   input  logic                      Reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      wb_hold,
   output logic                      Reg_Write,
   output logic [ADDR_W-1:0]         Reg_input_address,
   output logic [DATA_W-1:0]         Reg_input_data,
   output logic [SQUASH_CNT_W-1:0]   squash_cnt
`ifdef RF_WB_FORWARD_EN
   ,
   input  logic [ADDR_W-1:0]         fwd_addr1,
   input  logic [ADDR_W-1:0]         fwd_addr2,
   input  logic [ADDR_W-1:0]         fwd_addr3,
   output logic [2:0]                fwd_hit
`endif
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0]        rr_ptr_reg;
   logic [IDX_W-1:0]        grant_idx;
   logic [NUM_REQ-1:0]      req_eligible;
   logic [NUM_REQ-1:0]      grant;
   logic                    transfer;
   logic [ADDR_W-1:0]       win_addr;
   logic [DATA_W-1:0]       win_data;
   logic [ADDR_W-1:0]       req_addr_arr [NUM_REQ];
   logic [DATA_W-1:0]       req_data_arr [NUM_REQ];
   logic                    wr_en_reg;
   logic [ADDR_W-1:0]       wr_addr_reg;
   logic [DATA_W-1:0]       wr_data_reg;
   logic [SQUASH_CNT_W-1:0] squash_cnt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
         assign req_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Holding the port or sitting in reset removes every candidate, so ready stays low.
   assign req_eligible = (wb_hold || Reset) ? '0 : req_valid;

   rr_grant #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_grant (
      .req       (req_eligible),
      .ptr       (rr_ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready = grant;
   assign transfer  = |grant;
   assign win_addr  = req_addr_arr[grant_idx];
   assign win_data  = req_data_arr[grant_idx];

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         rr_ptr_reg     <= '0;
         wr_en_reg      <= 1'b0;
         wr_addr_reg    <= '0;
         wr_data_reg    <= '0;
         squash_cnt_reg <= '0;
      end else if (transfer) begin
         rr_ptr_reg <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
         if (win_addr != ADDR_W'(RF_ZERO_REG)) begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= win_addr;
            wr_data_reg <= win_data;
         end else begin
            // r0 is hard-wired zero: drop the write but keep a record of it.
            wr_en_reg <= 1'b0;
            if (squash_cnt_reg != SQUASH_CNT_MAX)
               squash_cnt_reg <= squash_cnt_reg + 1'b1;
         end
      end else begin
         wr_en_reg <= 1'b0;
      end
   end

   assign Reg_Write         = wr_en_reg;
   assign Reg_input_address = wr_addr_reg;
   assign Reg_input_data    = wr_data_reg;
   assign squash_cnt        = squash_cnt_reg;

`ifdef RF_WB_FORWARD_EN
   // Decode reads Reg_input_data directly before the negedge write lands in the file.
   assign fwd_hit[0] = wr_en_reg && (wr_addr_reg == fwd_addr1) && (fwd_addr1 != '0);
   assign fwd_hit[1] = wr_en_reg && (wr_addr_reg == fwd_addr2) && (fwd_addr2 != '0);
   assign fwd_hit[2] = wr_en_reg && (wr_addr_reg == fwd_addr3) && (fwd_addr3 != '0);
`endif
endmodule
